writeback: RTL
==============

Name: writeback

Overview:
- Writeback stage of the Lua processor pipeline; the consumer of the execute stage's result bundle (register id/value, memory address/value).
- Accepts one result per handshake.
- Commits the register result to the register-file write port in a single cycle.
- Drives a multi-cycle memory write request/acknowledge transaction.
- Counts retired instructions and flags a stalled memory port.

Parameters:
- MEM_TIMEOUT, 255, number of consecutive request cycles without mem_ack before the error state is entered (legal range 1..255).

Ports:
- clk_wb  input  1  stage clock, all state changes on rising edge
- n_reset  input  1  asynchronous active-low reset
- ex_valid  input  1  execute result bundle valid
- ex_ready  output  1  writeback can accept a bundle this cycle
- reg_we  input  1  bundle carries a register write
- mem_we  input  1  bundle carries a memory write
- reg_id  input  8  destination register index
- reg_val  input  32  register write data
- mem_addr  input  32  memory write address
- mem_val  input  32  memory write data
- rf_we  output  1  register-file write strobe, one cycle
- rf_id  output  8  register-file write index
- rf_val  output  32  register-file write data
- mem_req  output  1  memory write request, held until acknowledged
- mem_req_addr  output  32  memory request address
- mem_req_data  output  32  memory request data
- mem_ack  input  1  memory write accepted, sampled on rising edge
- wb_count  output  32  retired-bundle counter
- wb_error  output  1  sticky memory timeout flag

Behaviour:
- Clock and reset: one clock, clk_wb. Reset n_reset is asynchronous, active-low.
- Reset state, applied immediately on n_reset low:
  - state IDLE
  - rf_we=0, rf_id=0, rf_val=0
  - mem_req=0, mem_req_addr=0, mem_req_data=0
  - wb_count=0, wb_error=0, timer=0
- Reset mid-transaction: mem_req drops asynchronously and the pending bundle is discarded.
- ex_ready = (state==IDLE), decoded from registered state only. It is 0 while n_reset is low.
- States: IDLE, COMMIT, MEM_WAIT, ERROR.
- IDLE:
  - On ex_valid=1 at an edge, latch reg_we, mem_we, reg_id, reg_val, mem_addr, mem_val.
  - Go to COMMIT.
  - Inputs are ignored otherwise.
- COMMIT (exactly one cycle, starting one cycle after accept):
  - rf_we = latched reg_we; rf_id and rf_val driven with the latched values.
  - If latched mem_we=1:
    - mem_req=1, mem_req_addr and mem_req_data driven.
    - mem_ack=1 at the closing edge: retire, go to IDLE.
    - Otherwise: timer=1, go to MEM_WAIT.
  - If latched mem_we=0: retire and go to IDLE. This includes the NOP case, reg_we=0 and mem_we=0.
- MEM_WAIT:
  - mem_req=1; address and data held stable.
  - rf_we=0.
  - mem_ack=1 at an edge: retire, mem_req=0 next cycle, go to IDLE.
  - Else, if timer==MEM_TIMEOUT: go to ERROR.
  - Else: timer+1.
  - If ack arrives on the same edge the timeout would fire, ack wins.
- MEM_TIMEOUT=1: with no ack at the closing edge of COMMIT, the next MEM_WAIT edge enters ERROR.
- ERROR:
  - mem_req=0, wb_error=1, ex_ready=0.
  - Held until reset; wb_count is frozen.
- Retire: wb_count increments by 1 on the edge that leaves COMMIT or MEM_WAIT for IDLE. It wraps from 0xFFFFFFFF to 0.
- Throughput:
  - Register-only bundle: one per 2 cycles.
  - Memory bundle: 2 + wait cycles.
- rf_id and rf_val hold their last values when rf_we=0. mem_req_addr and mem_req_data hold when mem_req=0.
- Register index 0 is a legal write target with no special handling.
- Both writes in one bundle: rf_we and mem_req assert in the same COMMIT cycle. The register write is never repeated during MEM_WAIT.

Test Plan:
- Reset then idle: assert n_reset low mid-cycle → all outputs 0 immediately; ex_ready=1 one edge after release.
- Register write only: reg_we=1, reg_id=0x55, reg_val=123 → rf_we high for exactly one cycle, one cycle after accept, with rf_id=0x55, rf_val=123; wb_count=1; ex_ready back to 1 after 2 cycles.
- Combined write, ack after 3 cycles: mem_addr=567, mem_val=999 → rf_we pulse and mem_req rise together; mem_req_addr=567 and mem_req_data=999 stable until ack; mem_req falls the next cycle; wb_count increments once.
- Same-cycle ack in COMMIT: mem_ack tied high → mem_req high for exactly one cycle; back-to-back register bundles retire at one per 2 cycles; ex_valid held high while ex_ready=0 is not re-accepted.
- Timeout: MEM_TIMEOUT=4, mem_ack held low → wb_error=1 and mem_req=0 after the 5th request edge; ex_ready stays 0; async reset clears the error and recovers.
- Counter wrap and NOP: preload by issuing NOP bundles (reg_we=0, mem_we=0) → rf_we and mem_req never assert while wb_count advances; forced wrap from 0xFFFFFFFF reads 0.

Source files
------------

// File: rtl/writeback.sv
// Writeback stage: commits execute-stage results to the register file and
// drives a memory write request/acknowledge transaction with a timeout.
module writeback #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk_wb,
    input  logic        n_reset,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic        reg_we,
    input  logic        mem_we,
    input  logic [7:0]  reg_id,
    input  logic [31:0] reg_val,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_val,
    output logic        rf_we,
    output logic [7:0]  rf_id,
    output logic [31:0] rf_val,
    output logic        mem_req,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_data,
    input  logic        mem_ack,
    output logic [31:0] wb_count,
    output logic        wb_error
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        MEM_WAIT,
        ERROR
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(MEM_TIMEOUT);

    state_t      state;
    logic        pend_mem;
    logic [7:0]  timer;

    // Outputs are loaded on the accepting edge so they are valid throughout
    // COMMIT; ex_ready is a registered copy of "next state is IDLE" so it
    // stays low while reset is held and rises one edge after release.
    always_ff @(posedge clk_wb or negedge n_reset) begin
        if (!n_reset) begin
            state        <= IDLE;
            ex_ready     <= 1'b0;
            pend_mem     <= 1'b0;
            timer        <= 8'd0;
            rf_we        <= 1'b0;
            rf_id        <= 8'd0;
            rf_val       <= 32'd0;
            mem_req      <= 1'b0;
            mem_req_addr <= 32'd0;
            mem_req_data <= 32'd0;
            wb_count     <= 32'd0;
            wb_error     <= 1'b0;
        end else begin
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    ex_ready <= 1'b1;
                    if (ex_valid) begin
                        state    <= COMMIT;
                        ex_ready <= 1'b0;
                        pend_mem <= mem_we;
                        rf_we    <= reg_we;
                        if (reg_we) begin
                            rf_id  <= reg_id;
                            rf_val <= reg_val;
                        end
                        if (mem_we) begin
                            mem_req      <= 1'b1;
                            mem_req_addr <= mem_addr;
                            mem_req_data <= mem_val;
                        end
                    end
                end
                COMMIT: begin
                    if (pend_mem && !mem_ack) begin
                        timer <= 8'd1;
                        state <= MEM_WAIT;
                    end else begin
                        mem_req  <= 1'b0;
                        wb_count <= wb_count + 32'd1;
                        ex_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                MEM_WAIT: begin
                    // An acknowledge on the timeout edge still retires the bundle.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wb_count <= wb_count + 32'd1;
                        ex_ready <= 1'b1;
                        state    <= IDLE;
                    end else if (timer == TIMEOUT_LIMIT) begin
                        mem_req  <= 1'b0;
                        wb_error <= 1'b1;
                        state    <= ERROR;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                ERROR: begin
                    mem_req  <= 1'b0;
                    ex_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
